fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the PC register and drives a synchronous instruction memory with 1-cycle read latency.
- Produces the IF/ID pipeline register contents (CurrPC, CurrInstr, plus a valid bit) for the decode stage.
- Handles hazard stalls with a 1-entry hold buffer, branch redirect/flush, and the Halt stop condition.

Parameters:
- PC_W, 9, PC and instruction-address width in bits.
- INSTR_W, 32, instruction width in bits.
- RESET_PC, 9'h000, first fetch address after reset.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  hazard unit: hold PC and IF/ID this cycle.
- flush_i  in  1  EX-stage taken branch/jump: squash and redirect.
- redirect_pc_i  in  PC_W  target PC, valid when flush_i=1.
- halt_i  in  1  Halt flag from the ID/EX register.
- imem_addr_o  out  PC_W  instruction memory read address.
- imem_rdata_i  in  INSTR_W  memory data for the address presented in the previous cycle.
- ifid_pc_o  out  PC_W  IF/ID CurrPC.
- ifid_instr_o  out  INSTR_W  IF/ID CurrInstr.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- halted_o  out  1  fetch is permanently stopped.

Behaviour:
- Registers: fetch_pc, resp_pc, resp_valid, hold_pc, hold_instr, hold_valid, IF/ID outputs, state ∈ {RUN, HALTED}.
- imem_addr_o = fetch_pc, driven directly from the register.
- Async reset (reset_n=0), applied immediately:
  - fetch_pc=RESET_PC; resp_valid=0; hold_valid=0.
  - ifid_pc_o=0; ifid_instr_o=NOP_INSTR; ifid_valid_o=0; halted_o=0.
  - state=RUN.
- RUN, no stall/flush/halt:
  - IF/ID <= hold_valid ? {hold_pc, hold_instr, 1} : {resp_pc, imem_rdata_i, resp_valid}.
  - hold_valid<=0; resp_pc<=fetch_pc; resp_valid<=1; fetch_pc<=fetch_pc+4.
- Latency: first valid IF/ID is visible 2 cycles after reset release (addr cycle 0, data cycle 1, IF/ID cycle 2). Steady state is 1 instruction per cycle.
- Stall (stall_i=1, flush_i=0):
  - IF/ID, fetch_pc and resp_pc hold.
  - If hold_valid=0 and resp_valid=1: capture hold_pc<=resp_pc, hold_instr<=imem_rdata_i, hold_valid<=1.
  - On a multi-cycle stall, later imem_rdata_i (mem[fetch_pc]) is ignored.
  - On stall release, the normal rule applies: the hold buffer drains into IF/ID and the fetch restarts at fetch_pc, so no instruction is lost or duplicated.
- Flush (flush_i=1), takes priority over stall_i and halt_i:
  - fetch_pc<={redirect_pc_i[PC_W-1:2],2'b00}; resp_valid<=0; hold_valid<=0.
  - IF/ID <= {0, NOP_INSTR, 0}.
  - First redirected instruction is valid in IF/ID 2 cycles after the flush edge.
- Halt (halt_i=1, flush_i=0, state RUN):
  - state<=HALTED; IF/ID <= bubble; fetch_pc frozen.
  - halted_o=1 from the next cycle.
- HALTED:
  - stall_i, flush_i and halt_i are ignored.
  - IF/ID stays bubble; imem_addr_o stays constant.
  - Exit only via reset.
- Arithmetic: PC increments modulo 2^PC_W (9'h1FC+4 = 9'h000); no overflow flag.
- Reset asserted mid-stall or mid-flush discards the hold buffer and the in-flight response.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds output ports perf_stall_cnt_o[31:0] and perf_flush_cnt_o[31:0]:
  - perf_stall_cnt_o counts cycles with stall_i=1 in RUN.
  - perf_flush_cnt_o counts cycles with flush_i=1 in RUN.
  - Both counters saturate at 32'hFFFFFFFF and are cleared by reset_n.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, mem[i]=i, no stalls -> IF/ID sequence (pc,instr) = (0,0),(4,1),(8,2), starting cycle 2, valid every cycle.
- Stall high 3 cycles while IF/ID=(8,2) -> IF/ID holds (8,2); after release (12,3),(16,4) with no gap, duplicate or loss.
- flush_i with redirect_pc_i=9'h043 while stall_i=1 -> next IF/ID bubble (NOP, valid 0); fetch address 0x040; IF/ID=(0x40,mem[0x10]) 2 cycles later.
- halt_i pulse -> halted_o=1 next cycle; IF/ID bubble forever; later flush_i/stall_i have no effect; reset_n low restores PC 0.
- Fetch run from 0x1F8 -> IF/ID pc 0x1F8, 0x1FC, 0x000 (wrap).
- FETCH_PERF_CNT_EN defined: 5 stall cycles + 2 flushes -> counters read 5 and 2; forced near-max value saturates at 32'hFFFFFFFF.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage of a 5-stage RISC-V pipeline.
//
// Owns the fetch PC, drives a synchronous instruction memory with a 1-cycle
// read latency and fills the IF/ID pipeline register. A 1-entry hold buffer
// keeps the response that arrives during a hazard stall, a taken branch in EX
// squashes and redirects fetch, and a Halt stops fetch until reset.
//
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating stall/flush
// cycle counters and their output ports.
//
// Ports:
//   clk              pipeline clock, rising edge
//   reset_n          asynchronous active-low reset
//   stall_i          hold PC and IF/ID this cycle
//   flush_i          squash and redirect to redirect_pc_i (highest priority)
//   redirect_pc_i    branch/jump target, used when flush_i=1
//   halt_i           Halt flag from ID/EX; stops fetch permanently
//   imem_addr_o      instruction memory read address
//   imem_rdata_i     memory data for the address of the previous cycle
//   ifid_pc_o        IF/ID CurrPC
//   ifid_instr_o     IF/ID CurrInstr
//   ifid_valid_o     IF/ID holds a real instruction
//   halted_o         fetch is permanently stopped
//   perf_stall_cnt_o (FETCH_PERF_CNT_EN) stall cycles seen while running
//   perf_flush_cnt_o (FETCH_PERF_CNT_EN) flush cycles seen while running
module fetch_stage #(
  parameter int unsigned          PC_W      = 9,
  parameter int unsigned          INSTR_W   = 32,
  parameter logic [PC_W-1:0]      RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h00000013
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  input  logic               halt_i,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [PC_W-1:0]    ifid_pc_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic               ifid_valid_o,
  output logic               halted_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cnt_o,
  output logic [31:0]        perf_flush_cnt_o
`endif
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    resp_pc_q, resp_pc_d;
  logic               resp_valid_q, resp_valid_d;
  logic [PC_W-1:0]    hold_pc_q, hold_pc_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  logic               hold_valid_q, hold_valid_d;
  logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic               ifid_valid_q, ifid_valid_d;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    hold_valid_d = hold_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;

    // In HALTED every input is ignored: IF/ID already holds a bubble and the
    // fetch address is frozen, so the defaults above are the whole story.
    if (state_q == RUN) begin
      if (flush_i) begin
        // Word-align the target; masking keeps every redirect bit in use.
        fetch_pc_d   = redirect_pc_i & ~PC_W'(3);
        resp_valid_d = 1'b0;
        hold_valid_d = 1'b0;
        ifid_pc_d    = '0;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end else if (halt_i) begin
        state_d      = HALTED;
        ifid_pc_d    = '0;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end else if (stall_i) begin
        // Only the first stalled cycle carries the response for resp_pc;
        // later cycles return mem[fetch_pc], which is refetched on release.
        if (!hold_valid_q && resp_valid_q) begin
          hold_pc_d    = resp_pc_q;
          hold_instr_d = imem_rdata_i;
          hold_valid_d = 1'b1;
        end
      end else begin
        if (hold_valid_q) begin
          ifid_pc_d    = hold_pc_q;
          ifid_instr_d = hold_instr_q;
          ifid_valid_d = 1'b1;
        end else begin
          ifid_pc_d    = resp_pc_q;
          ifid_instr_d = imem_rdata_i;
          ifid_valid_d = resp_valid_q;
        end
        hold_valid_d = 1'b0;
        resp_pc_d    = fetch_pc_q;
        resp_valid_d = 1'b1;
        fetch_pc_d   = fetch_pc_q + PC_W'(4);  // wraps modulo 2^PC_W
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      fetch_pc_q   <= RESET_PC;
      resp_pc_q    <= '0;
      resp_valid_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      hold_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_valid_q <= hold_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_addr_o  = fetch_pc_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_valid_o = ifid_valid_q;
  assign halted_o     = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Saturating counters; they freeze once fetch has halted.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (state_q == RUN) begin
      if (stall_i && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_d = perf_stall_q + 32'd1;
      end
      if (flush_i && (perf_flush_q != 32'hFFFF_FFFF)) begin
        perf_flush_d = perf_flush_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule
